// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO of fetch entries with clear
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Pointer/occupancy update; a push into a full FIFO is only legal alongside a pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !clear));

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: pc, imem issue, response buffering, redirect
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_pc_in,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        instr_valid_o,
    output logic        flush_o,
    output logic        misalign_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic          misalign_q, misalign_d;

    logic [CW:0]   occupancy;
    logic          grant, resp, branch_act, branch_bad, drop;
    logic          ibuf_push, ibuf_pop;
    fetch_entry_t  ibuf_in, ibuf_head, tag_in, tag_head;
    logic          ibuf_full, ibuf_empty, tag_full, tag_empty;
    logic [CW-1:0] ibuf_count, tag_count;
    logic          unused_tag;

    assign grant      = imem_req_o && imem_gnt_in;
    assign resp       = imem_rvalid_in && (outstanding_q != '0);
    assign branch_act = branch_taken_in && (state_q != ST_HALT);
    assign branch_bad = branch_act && (branch_pc_in[1:0] != 2'b00);
    assign drop       = resp && ((discard_q != '0) || branch_act);
    assign ibuf_pop   = instr_valid_o && !stall_in;
    assign ibuf_push  = resp && !drop;
    assign ibuf_in    = '{pc: tag_head.pc, instr: imem_rdata_in};
    assign tag_in     = '{pc: pc_q, instr: NOP_INSTR};
    assign unused_tag = ^{tag_head.instr, tag_full, tag_empty, tag_count, ibuf_full};

    // Issue gate: live in-flight words plus buffered words must leave a free slot;
    // the word leaving this cycle is credited so a steady stream runs without bubbles
    always_comb begin
        occupancy  = {1'b0, outstanding_q} - {1'b0, discard_q}
                   + {1'b0, ibuf_count} - (CW+1)'(ibuf_pop);
        imem_req_o = (state_q == ST_RUN)
                   && (occupancy < (CW+1)'(FIFO_DEPTH))
                   && (outstanding_q < CW'(FIFO_DEPTH));
    end

    // Next-state for pc, FSM and the in-flight/discard counters; redirect wins over pc+4
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        misalign_d    = misalign_q || branch_bad;
        outstanding_d = outstanding_q + CW'(grant) - CW'(resp);
        discard_d     = discard_q;
        if (branch_act) begin
            discard_d = outstanding_d;
        end else if (resp && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end
        if (branch_act && !branch_bad) begin
            pc_d = branch_pc_in;
        end else if (grant) begin
            pc_d = pc_q + 32'd4;
        end
        case (state_q)
            ST_BOOT: state_d = branch_bad ? ST_HALT : ST_RUN;
            ST_RUN:  state_d = branch_bad ? ST_HALT : ST_RUN;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_BOOT;
        endcase
    end

    // Control registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            misalign_q    <= misalign_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_ibuf (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .clear     (branch_act),
        .push      (ibuf_push),
        .push_data (ibuf_in),
        .pop       (ibuf_pop),
        .head      (ibuf_head),
        .full      (ibuf_full),
        .empty     (ibuf_empty),
        .count     (ibuf_count)
    );

    // Tag queue tracks the pc of every granted request; never cleared by a redirect
    // because stale responses still have to retire their tag in order
    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_tags (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .clear     (1'b0),
        .push      (grant),
        .push_data (tag_in),
        .pop       (resp),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    assign imem_addr_o   = pc_q;
    assign instr_valid_o = !ibuf_empty;
    assign instr_o       = instr_valid_o ? ibuf_head.instr : NOP_INSTR;
    assign pc_o          = instr_valid_o ? ibuf_head.pc : 32'h0;
    assign flush_o       = !instr_valid_o || branch_taken_in;
    assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        stall_in;
    logic        branch_taken_in;
    logic [31:0] branch_pc_in;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;
    logic        flush_o;
    logic        misalign_o;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } pend_t;

    pend_t       pend_q[$];
    logic [63:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          resp_en;
    bit          last_fire, last_resp;
    logic [31:0] last_faddr;

    always #5 clk_in = ~clk_in;

    fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .stall_in        (stall_in),
        .branch_taken_in (branch_taken_in),
        .branch_pc_in    (branch_pc_in),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_in     (imem_gnt_in),
        .imem_rvalid_in  (imem_rvalid_in),
        .imem_rdata_in   (imem_rdata_in),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .instr_valid_o   (instr_valid_o),
        .flush_o         (flush_o),
        .misalign_o      (misalign_o)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[13:2], 5'd0, 3'b000, 5'd1, 7'h13};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive imem response, check outputs pre-edge, advance the model post-edge
    task automatic step(input bit br, input logic [31:0] tgt);
        bit          fire, resp, exp_valid;
        logic [31:0] faddr;
        pend_t       e;
        branch_taken_in = br;
        branch_pc_in    = tgt;
        resp            = resp_en && (pend_q.size() != 0);
        imem_rvalid_in  = resp;
        imem_rdata_in   = resp ? instr_of(pend_q[0].addr) : 32'h0;
        #1;
        fire      = imem_req_o && imem_gnt_in;
        faddr     = imem_addr_o;
        exp_valid = (exp_q.size() != 0);
        check_eq("valid", instr_valid_o, exp_valid);
        check_eq("flush", flush_o, !exp_valid || br);
        if (!instr_valid_o)
            check_eq("idle_out", {instr_o, pc_o}, {NOP_INSTR, 32'h0});
        else if (!stall_in && !br && exp_valid)
            check_eq("sb_word", {pc_o, instr_o}, exp_q.pop_front());
        @(posedge clk_in);
        @(negedge clk_in);
        if (br) begin
            exp_q.delete();
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
        end
        if (resp) begin
            e = pend_q.pop_front();
            if (!e.stale && !br) exp_q.push_back({e.addr, instr_of(e.addr)});
        end
        if (fire) pend_q.push_back('{addr: faddr, stale: br});
        last_fire       = fire;
        last_resp       = resp;
        last_faddr      = faddr;
        branch_taken_in = 1'b0;
        imem_rvalid_in  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!instr_valid_o && n < 20) begin
            step(1'b0, 32'h0);
            n++;
        end
        check_eq(tag, instr_valid_o, 1'b1);
    endtask

    task automatic wait_fire_resp(input string tag);
        int n = 0;
        while (!(imem_req_o && pend_q.size() != 0) && n < 20) begin
            step(1'b0, 32'h0);
            n++;
        end
        check_eq(tag, imem_req_o && pend_q.size() != 0, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq(tag, {imem_req_o, instr_valid_o, instr_o, pc_o, flush_o, misalign_o},
                 {1'b0, 1'b0, NOP_INSTR, 32'h0, 1'b1, 1'b0});
    endtask

    task automatic do_reset();
        rst_n_in        = 1'b0;
        stall_in        = 1'b0;
        branch_taken_in = 1'b0;
        imem_rvalid_in  = 1'b0;
        pend_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n_in        = 1'b0;
        stall_in        = 1'b0;
        branch_taken_in = 1'b0;
        branch_pc_in    = 32'h0;
        imem_gnt_in     = 1'b1;
        imem_rvalid_in  = 1'b0;
        imem_rdata_in   = 32'h0;
        resp_en         = 1'b1;
        repeat (2) @(negedge clk_in);
        #1;
        check_reset_outputs("reset_out");

        // 1: boot, first fetch at 0, back-to-back delivery
        @(negedge clk_in);
        rst_n_in = 1'b1;
        check_eq("boot_idle", imem_req_o, 1'b0);
        step(1'b0, 32'h0);
        check_eq("t1_first_req", {imem_req_o, imem_addr_o}, {1'b1, 32'h0});
        wait_valid("t1_valid");
        for (int k = 0; k < 3; k++) begin
            check_eq("t1_pc_seq", {instr_valid_o, flush_o, pc_o}, {1'b1, 1'b0, 32'(4 * k)});
            step(1'b0, 32'h0);
        end

        // 2: decode stall holds outputs and stops issue once buffered
        repeat (2) step(1'b0, 32'h0);
        stall_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 32'h0);
            check_eq("t2_have_exp", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check_eq("t2_frozen", {pc_o, instr_o}, exp_q[0]);
        end
        check_eq("t2_req_off", {imem_req_o, 32'(exp_q.size())}, {1'b0, 32'd2});
        stall_in = 1'b0;
        repeat (8) step(1'b0, 32'h0);

        // 3: redirect with two requests in flight
        resp_en = 1'b0;
        repeat (6) step(1'b0, 32'h0);
        check_eq("t3_inflight", {imem_req_o, instr_valid_o, 32'(pend_q.size())}, {1'b0, 1'b0, 32'd2});
        step(1'b1, 32'h0000_0100);
        resp_en = 1'b1;
        wait_valid("t3_valid");
        check_eq("t3_target", pc_o, 32'h0000_0100);

        // 4: redirect coinciding with a grant and a response
        wait_fire_resp("t4_setup");
        step(1'b1, 32'h0000_0200);
        check_eq("t4_both", {last_fire, last_resp}, 2'b11);
        check_eq("t4_new_req", {imem_req_o, imem_addr_o}, {1'b1, 32'h0000_0200});
        wait_valid("t4_valid");
        check_eq("t4_target", pc_o, 32'h0000_0200);

        // 5: misaligned redirect halts until reset; later redirects ignored
        repeat (3) step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0102);
        check_eq("t5_misalign", misalign_o, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 32'h0);
            check_eq("t5_halt", {imem_req_o, flush_o, misalign_o}, 3'b011);
        end
        step(1'b1, 32'h0000_0300);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 32'h0);
            check_eq("t5_halt_br", {imem_req_o, misalign_o}, 2'b01);
        end
        rst_n_in = 1'b0;
        #1;
        check_reset_outputs("t5_reset");
        do_reset();

        // 6: redirect during BOOT, pc wrap, async reset mid-burst
        step(1'b1, 32'hFFFF_FFF8);
        check_eq("t6_boot_br", {imem_req_o, imem_addr_o}, {1'b1, 32'hFFFF_FFF8});
        n = 0;
        while (!(last_fire && last_faddr == 32'hFFFF_FFFC) && n < 20) begin
            step(1'b0, 32'h0);
            n++;
        end
        check_eq("t6_wrap", {last_fire, last_faddr, imem_addr_o}, {1'b1, 32'hFFFF_FFFC, 32'h0});
        wait_valid("t6_valid");
        check_eq("t6_pc0", pc_o, 32'hFFFF_FFF8);
        step(1'b0, 32'h0);
        check_eq("t6_pc1", pc_o, 32'hFFFF_FFFC);
        step(1'b0, 32'h0);
        check_eq("t6_pc2", pc_o, 32'h0000_0000);
        step(1'b0, 32'h0);
        #2;
        rst_n_in = 1'b0;
        #1;
        check_reset_outputs("t6_async_reset");
        do_reset();
        #1;
        check_eq("t6_post_reset", {imem_req_o, instr_valid_o, misalign_o}, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
